// File: rtl/add_sub_align_seq.sv
// Exponent-alignment sequencer for the FPU add/sub path: picks the larger operand and
// right-shifts the smaller mantissa through an external narrow shifter, tracking sticky.
module add_sub_align_seq #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 24,
    parameter int SIZE_DATA  = MAN_W + 3,
    parameter int SIZE_SHIFT = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [EXP_W-1:0]      i_exp_a,
    input  logic [EXP_W-1:0]      i_exp_b,
    input  logic [MAN_W-1:0]      i_man_a,
    input  logic [MAN_W-1:0]      i_man_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [EXP_W-1:0]      o_exp,
    output logic                  o_swap,
    output logic [SIZE_DATA-1:0]  o_man_big,
    output logic [SIZE_DATA-1:0]  o_man_small,
    output logic [SIZE_SHIFT-1:0] o_shf_number,
    output logic [SIZE_DATA-1:0]  o_shf_data,
    input  logic [SIZE_DATA-1:0]  i_shf_data,
    output logic [1:0]            o_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // the source holds its data stable from raising valid until that edge.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [EXP_W-1:0] MAX_STEP   = EXP_W'(2**SIZE_SHIFT - 1);
    localparam logic [EXP_W-1:0] FLUSH_DIFF = EXP_W'(SIZE_DATA);

    logic [1:0]            state;
    logic [EXP_W-1:0]      exp_big;
    logic                  swap;
    logic [SIZE_DATA-1:0]  man_big;
    logic [SIZE_DATA-1:0]  data;
    logic [EXP_W-1:0]      rem;
    logic                  sticky;

    logic                  a_big;
    logic [EXP_W-1:0]      diff;
    logic [MAN_W-1:0]      man_big_in;
    logic [MAN_W-1:0]      man_small_in;
    logic [EXP_W-1:0]      step_wide;
    logic [SIZE_SHIFT-1:0] step;
    logic [SIZE_DATA-1:0]  mask;

    always_comb begin
        a_big        = (i_exp_a >= i_exp_b);
        diff         = a_big ? (i_exp_a - i_exp_b) : (i_exp_b - i_exp_a);
        man_big_in   = a_big ? i_man_a : i_man_b;
        man_small_in = a_big ? i_man_b : i_man_a;
        step_wide    = (rem > MAX_STEP) ? MAX_STEP : rem;
        step         = step_wide[SIZE_SHIFT-1:0];
        // Bits of data that fall off the bottom during this pass.
        mask         = ~({SIZE_DATA{1'b1}} << step);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            exp_big <= '0;
            swap    <= 1'b0;
            man_big <= '0;
            data    <= '0;
            rem     <= '0;
            sticky  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        exp_big <= a_big ? i_exp_a : i_exp_b;
                        swap    <= ~a_big;
                        man_big <= {man_big_in, 3'b000};
                        rem     <= diff;
                        if (diff == '0) begin
                            data   <= {man_small_in, 3'b000};
                            sticky <= 1'b0;
                            state  <= S_DONE;
                        end else if (diff >= FLUSH_DIFF) begin
                            data   <= '0;
                            sticky <= |man_small_in;
                            state  <= S_DONE;
                        end else begin
                            data   <= {man_small_in, 3'b000};
                            sticky <= 1'b0;
                            state  <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data   <= i_shf_data;
                    sticky <= sticky | (|(data & mask));
                    rem    <= rem - step_wide;
                    if (rem == step_wide) state <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_ready      = (state == S_IDLE);
    assign o_valid      = (state == S_DONE);
    assign o_exp        = exp_big;
    assign o_swap       = swap;
    assign o_man_big    = man_big;
    assign o_man_small  = {data[SIZE_DATA-1:1], data[0] | sticky};
    assign o_shf_data   = data;
    assign o_shf_number = (state == S_SHIFT) ? step : '0;
    assign o_state      = state;

endmodule
